reg_exec_unit: RTL and testbench
================================

# reg_exec_unit

Single-issue execute/writeback engine that sits directly upstream of the register file and drives both of its read-address ports and its write port. It accepts one register-to-register operation at a time over a valid/ready handshake, reads both source operands, and computes the result (single-cycle logic ops, or a multi-cycle shift-add multiply). It then writes the result back to the register file. Only one operation is in flight, so a dependent operation issued next always observes the previous result.

## Interface
- ADDR_WIDTH, 3, register address width (2^ADDR_WIDTH registers)
- REG_WIDTH, 32, register data width
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  operation request
- o_ready  out  1  unit idle, request accepted when i_valid && o_ready at an edge
- i_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6–7 illegal
- i_rd, i_rs1, i_rs2  in  ADDR_WIDTH  destination / source register numbers
- o_reg_a_addr_r, o_reg_b_addr_r  out  ADDR_WIDTH  to register file read ports (rs1, rs2)
- i_reg_a_val_r, i_reg_b_val_r  in  REG_WIDTH  combinational read data from register file
- o_reg_addr_w  out  ADDR_WIDTH  write address
- o_reg_val_w  out  REG_WIDTH  write data
- o_write_en  out  1  write strobe; register file writes on the edge ending a high cycle
- o_illegal  out  1  one-cycle pulse for a rejected opcode

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE:
  - o_ready=1.
  - On accept, latch op/rd/rs1/rs2 and go to READ.
- READ:
  - o_reg_a_addr_r / o_reg_b_addr_r are driven from the latched rs1/rs2 (registered, stable all cycle).
  - At the edge, capture i_reg_a_val_r/i_reg_b_val_r into operand registers.
  - Legal op: go to EXEC. Illegal op: go to WB with the illegal flag set.
- EXEC:
  - ADD/SUB/AND/OR/XOR: result registered in one cycle, then go to WB.
  - MUL: REG_WIDTH cycles of shift-add.
    - Each cycle: if multiplier[0], acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1.
    - A cycle counter runs 0..REG_WIDTH-1; go to WB after the last cycle.
- WB:
  - Legal op: o_write_en=1, o_reg_addr_w=rd, o_reg_val_w=result.
  - Illegal op: o_write_en=0 and o_illegal=1.
  - Always return to IDLE.
- Arithmetic: all results are modulo 2^REG_WIDTH. SUB is rs1−rs2 wrapping. MUL keeps the low REG_WIDTH bits of the unsigned product.
- Register 0 is an ordinary register, writable like any other.
- rs1==rs2 and rd==rs1/rs2 are legal. Operands are captured in READ, so aliasing has no effect on the result.
- i_valid while o_ready=0 is ignored. The requester must hold its request until accepted.

## Timing
- Reset values:
  - state=IDLE, o_ready=1, o_write_en=0, o_illegal=0.
  - o_reg_addr_w=0, o_reg_val_w=0, o_reg_a_addr_r=0, o_reg_b_addr_r=0.
  - Operands, accumulator and counter = 0.
- Let E0 be the accept edge:
  - ALU op: READ in cycle after E0, EXEC after E1, WB after E2, register file write at E3. o_ready high again after E3; earliest next accept is E4.
  - MUL: EXEC spans E1..E1+REG_WIDTH; write at E(REG_WIDTH+2), i.e. E34 for REG_WIDTH=32.
  - Illegal op: o_illegal high in the cycle after E1; IDLE after E2.
- o_write_en and o_illegal are each high for exactly one cycle per operation, never both.
- Reset asserted in any state:
  - Return to IDLE at that edge and abandon the in-flight op.
  - No write may occur, including if reset coincides with WB (o_write_en forced 0 that cycle).

## Structure
- reg_exec_pkg holds:
  - op_e enum (ADD..MUL plus the illegal range).
  - state_e enum (IDLE, READ, EXEC, WB).
  - is_legal_op function.
- Sub-module reg_exec_mul: iterative multiplier with start/busy/done and a product output.
  - Parameterised by REG_WIDTH.
  - Same i_clk/i_rst.
  - Top FSM stays in EXEC until done.

## Test plan
- Common setup: the bench instantiates reg_file plus a harness write-port mux to seed registers, then hands the write port to the unit.
- r1=5, r2=7; ADD rd=3 -> exactly one o_write_en cycle with addr 3, data 12, at E3; reading r3 returns 12.
- r1=0, r2=1; SUB rd=2 -> r2=0xFFFF_FFFF. Then XOR rd=4 with rs1=rs2=2 -> r4=0.
- r1=0x0001_0003, r2=0x0002_0005; MUL rd=5 -> write at E34 with data 0x000B_000F; o_ready low E0..E34.
- ADD r3=r1+r2 (r1=5, r2=7), then immediately ADD r6=r3+r3 -> r6=24 (dependent op sees the new value); second accept no earlier than E4.
- op=7 -> o_illegal pulses once, o_write_en never high, all registers unchanged, o_ready returns after E2.
- Start MUL, assert i_rst at E10 -> no write occurs, o_ready=1 after E10, and a following ADD completes normally.

Source files
------------

// File: rtl/reg_exec_pkg.sv
// Shared types and helpers for the register execute/writeback unit.
package reg_exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MUL  = 3'd5,
        OP_ILL6 = 3'd6,
        OP_ILL7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic is_legal_op(input op_e op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/reg_exec_if.sv
// Request handshake plus register-file read/write ports of the execute unit.
interface reg_exec_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 32
);
    logic                  i_valid;
    logic                  o_ready;
    logic [2:0]            i_op;
    logic [ADDR_WIDTH-1:0] i_rd;
    logic [ADDR_WIDTH-1:0] i_rs1;
    logic [ADDR_WIDTH-1:0] i_rs2;
    logic [ADDR_WIDTH-1:0] o_reg_a_addr_r;
    logic [ADDR_WIDTH-1:0] o_reg_b_addr_r;
    logic [REG_WIDTH-1:0]  i_reg_a_val_r;
    logic [REG_WIDTH-1:0]  i_reg_b_val_r;
    logic [ADDR_WIDTH-1:0] o_reg_addr_w;
    logic [REG_WIDTH-1:0]  o_reg_val_w;
    logic                  o_write_en;
    logic                  o_illegal;

    modport slave (
        input  i_valid, i_op, i_rd, i_rs1, i_rs2, i_reg_a_val_r, i_reg_b_val_r,
        output o_ready, o_reg_a_addr_r, o_reg_b_addr_r, o_reg_addr_w, o_reg_val_w,
               o_write_en, o_illegal
    );

    modport master (
        output i_valid, i_op, i_rd, i_rs1, i_rs2, i_reg_a_val_r, i_reg_b_val_r,
        input  o_ready, o_reg_a_addr_r, o_reg_b_addr_r, o_reg_addr_w, o_reg_val_w,
               o_write_en, o_illegal
    );
endinterface

// File: rtl/reg_exec_mul.sv
// Iterative shift-add multiplier, one partial product per cycle, low REG_WIDTH bits kept.
module reg_exec_mul #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [REG_WIDTH-1:0] i_multiplicand,
    input  logic [REG_WIDTH-1:0] i_multiplier,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [REG_WIDTH-1:0] o_product
);
    localparam int              CNT_W = $clog2(REG_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REG_WIDTH - 1);

    logic [REG_WIDTH-1:0] mcand_reg;
    logic [REG_WIDTH-1:0] mplier_reg;
    logic [REG_WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 busy_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (i_start) begin
            mcand_reg  <= i_multiplicand;
            mplier_reg <= i_multiplier;
            acc_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
            if (count_reg == LAST) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge adds the final partial product
    assign o_done    = busy_reg && (count_reg == LAST);
    assign o_busy    = busy_reg;
    assign o_product = acc_reg;

endmodule

// File: rtl/reg_exec_unit.sv
// Single-issue execute/writeback engine: READ operands, EXEC (ALU or iterative MUL), WB to register file.
module reg_exec_unit
    import reg_exec_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 32
) (
    input  logic      i_clk,
    input  logic      i_rst,
    reg_exec_if.slave bus
);
    state_e                state_reg, state_next;
    op_e                   op_reg;
    logic [ADDR_WIDTH-1:0] rd_reg, rs1_reg, rs2_reg;
    logic [REG_WIDTH-1:0]  opa_reg, opb_reg, result_reg;
    logic                  illegal_reg;

    logic [REG_WIDTH-1:0]  and_bits, or_bits, xor_bits;
    logic [REG_WIDTH-1:0]  alu_result;
    logic                  mul_start, mul_busy, mul_done;
    logic [REG_WIDTH-1:0]  mul_product;
    logic                  accept;

    assign accept = bus.i_valid && bus.o_ready;

    for (genvar gi = 0; gi < REG_WIDTH; gi++) begin : g_bitwise
        assign and_bits[gi] = opa_reg[gi] & opb_reg[gi];
        assign or_bits[gi]  = opa_reg[gi] | opb_reg[gi];
        assign xor_bits[gi] = opa_reg[gi] ^ opb_reg[gi];
    end

    always_comb begin
        alu_result = '0;
        case (op_reg)
            OP_ADD:  alu_result = opa_reg + opb_reg;
            OP_SUB:  alu_result = opa_reg - opb_reg;
            OP_AND:  alu_result = and_bits;
            OP_OR:   alu_result = or_bits;
            OP_XOR:  alu_result = xor_bits;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_ADD;
            rd_reg      <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            result_reg  <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg      <= op_e'(bus.i_op);
                        rd_reg      <= bus.i_rd;
                        rs1_reg     <= bus.i_rs1;
                        rs2_reg     <= bus.i_rs2;
                        illegal_reg <= 1'b0;
                    end
                end
                ST_READ: begin
                    opa_reg     <= bus.i_reg_a_val_r;
                    opb_reg     <= bus.i_reg_b_val_r;
                    illegal_reg <= !is_legal_op(op_reg);
                end
                ST_EXEC: begin
                    if (op_reg != OP_MUL) begin
                        result_reg <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_READ;
            ST_READ: begin
                if (is_legal_op(op_reg)) begin
                    state_next = ST_EXEC;
                    // multiplier loads straight from the read ports so its first step lands on the first EXEC edge
                    mul_start  = (op_reg == OP_MUL);
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_EXEC: begin
                if (op_reg != OP_MUL || mul_done) state_next = ST_WB;
            end
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    reg_exec_mul #(.REG_WIDTH(REG_WIDTH)) u_mul (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (mul_start),
        .i_multiplicand (bus.i_reg_a_val_r),
        .i_multiplier   (bus.i_reg_b_val_r),
        .o_busy         (mul_busy),
        .o_done         (mul_done),
        .o_product      (mul_product)
    );

    assign bus.o_ready        = (state_reg == ST_IDLE) && !mul_busy;
    assign bus.o_reg_a_addr_r = rs1_reg;
    assign bus.o_reg_b_addr_r = rs2_reg;
    assign bus.o_reg_addr_w   = rd_reg;
    assign bus.o_reg_val_w    = (op_reg == OP_MUL) ? mul_product : result_reg;
    // reset landing on WB must suppress the write in that same cycle
    assign bus.o_write_en     = (state_reg == ST_WB) && !illegal_reg && !i_rst;
    assign bus.o_illegal      = (state_reg == ST_WB) && illegal_reg && !i_rst;

endmodule

// File: tb/tb_reg_exec_unit.sv
// Directed bench: register-file model with seeding mux, vector table plus multi-cycle corner sequences.
module tb_reg_exec_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_exec_if #(.ADDR_WIDTH(3), .REG_WIDTH(32)) bus ();

    reg_exec_unit #(.ADDR_WIDTH(3), .REG_WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // register file model with harness write-port mux
    logic [31:0] regs [8];
    logic        seed_mode = 1'b0;
    logic [2:0]  seed_addr = '0;
    logic [31:0] seed_data = '0;

    always @(posedge clk) begin
        if (seed_mode) regs[seed_addr] <= seed_data;
        else if (bus.o_write_en) regs[bus.o_reg_addr_w] <= bus.o_reg_val_w;
    end

    assign bus.i_reg_a_val_r = regs[bus.o_reg_a_addr_r];
    assign bus.i_reg_b_val_r = regs[bus.o_reg_b_addr_r];

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        seed;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] exp;
        int          wr_edge;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic seed_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        seed_mode = 1'b1;
        seed_addr = a;
        seed_data = d;
        @(posedge clk);
        #1 seed_mode = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, output int wr_cnt, output int wr_edge,
                          output logic [2:0] wr_addr, output logic [31:0] wr_data,
                          output int ill_cnt, output int ill_edge, output int rdy_edge);
        int w;
        wr_cnt = 0; wr_edge = -1; wr_addr = '0; wr_data = '0;
        ill_cnt = 0; ill_edge = -1; rdy_edge = -1;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_rd    = rd;
        bus.i_rs1   = rs1;
        bus.i_rs2   = rs2;
        w = 0;
        while (!bus.o_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        for (int k = 1; k <= 60 && rdy_edge < 0; k++) begin
            @(negedge clk);
            if (bus.o_write_en) begin
                wr_cnt++;
                if (wr_edge < 0) begin
                    wr_edge = k;
                    wr_addr = bus.o_reg_addr_w;
                    wr_data = bus.o_reg_val_w;
                end
            end
            if (bus.o_illegal) begin
                ill_cnt++;
                if (ill_edge < 0) ill_edge = k;
            end
            if (bus.o_ready) rdy_edge = k;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int wc, we_k, ic, ie, re, acc_k, late_wr;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [31:0] snap [8];

        vecs[0] = '{3'd0, 3'd3, 3'd1, 3'd2, 1'b1, 32'd5,         32'd7,         32'd12,        3};
        vecs[1] = '{3'd1, 3'd2, 3'd1, 3'd2, 1'b1, 32'd0,         32'd1,         32'hFFFF_FFFF, 3};
        vecs[2] = '{3'd4, 3'd4, 3'd2, 3'd2, 1'b0, 32'd0,         32'd0,         32'h0000_0000, 3};
        vecs[3] = '{3'd5, 3'd5, 3'd1, 3'd2, 1'b1, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 34};
        vecs[4] = '{3'd2, 3'd0, 3'd1, 3'd2, 1'b1, 32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, 3};
        vecs[5] = '{3'd3, 3'd7, 3'd1, 3'd2, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 3};
        vecs[6] = '{3'd0, 3'd6, 3'd1, 3'd2, 1'b1, 32'hFFFF_FFFF, 32'd2,         32'd1,         3};
        vecs[7] = '{3'd5, 3'd1, 3'd1, 3'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         34};
        vecs[8] = '{3'd5, 3'd2, 3'd3, 3'd4, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0,         34};
        vecs[9] = '{3'd1, 3'd3, 3'd3, 3'd4, 1'b1, 32'd5,         32'd9,         32'hFFFF_FFFC, 3};

        bus.i_valid = 1'b0;
        bus.i_op    = '0;
        bus.i_rd    = '0;
        bus.i_rs1   = '0;
        bus.i_rs2   = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",    32'(bus.o_ready),        32'd1);
        check("rst_write_en", 32'(bus.o_write_en),     32'd0);
        check("rst_illegal",  32'(bus.o_illegal),      32'd0);
        check("rst_addr_w",   32'(bus.o_reg_addr_w),   32'd0);
        check("rst_val_w",    bus.o_reg_val_w,         32'd0);
        check("rst_addr_a",   32'(bus.o_reg_a_addr_r), 32'd0);
        check("rst_addr_b",   32'(bus.o_reg_b_addr_r), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) seed_reg(3'(i), 32'h100 + 32'(i));

        // table-driven vectors
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].seed) begin
                seed_reg(vecs[v].rs1, vecs[v].v1);
                seed_reg(vecs[v].rs2, vecs[v].v2);
            end
            run_op(vecs[v].op, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, wc, we_k, wa, wd, ic, ie, re);
            $display("vec %0d op=%0d rd=%0d rs1=%0d rs2=%0d wr_edge=%0d data=%h", v, vecs[v].op,
                     vecs[v].rd, vecs[v].rs1, vecs[v].rs2, we_k, wd);
            check($sformatf("v%0d_wr_count", v), 32'(wc), 32'd1);
            check($sformatf("v%0d_wr_edge", v), 32'(we_k), 32'(vecs[v].wr_edge));
            check($sformatf("v%0d_wr_addr", v), 32'(wa), 32'(vecs[v].rd));
            check($sformatf("v%0d_wr_data", v), wd, vecs[v].exp);
            check($sformatf("v%0d_illegal", v), 32'(ic), 32'd0);
            check($sformatf("v%0d_ready_edge", v), 32'(re), 32'(vecs[v].wr_edge + 1));
            check($sformatf("v%0d_regfile", v), regs[vecs[v].rd], vecs[v].exp);
        end

        // back-to-back dependent ADD: r3=r1+r2, then r6=r3+r3 held from the cycle after E0
        seed_reg(3'd1, 32'd5);
        seed_reg(3'd2, 32'd7);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_op = 3'd0; bus.i_rd = 3'd3; bus.i_rs1 = 3'd1; bus.i_rs2 = 3'd2;
        @(posedge clk);
        #1 bus.i_rd = 3'd6; bus.i_rs1 = 3'd3; bus.i_rs2 = 3'd3;
        acc_k = -1;
        for (int k = 1; k <= 20 && acc_k < 0; k++) begin
            @(negedge clk);
            if (bus.o_ready) acc_k = k;
        end
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        we_k = -1; wd = '0;
        for (int k = 1; k <= 10 && we_k < 0; k++) begin
            @(negedge clk);
            if (bus.o_write_en) begin
                we_k = k;
                wd   = bus.o_reg_val_w;
            end
        end
        repeat (2) @(negedge clk);
        $display("dep accept_edge=%0d wr_edge=%0d data=%h", acc_k, we_k, wd);
        check("dep_accept_edge", 32'(acc_k), 32'd4);
        check("dep_wr_edge", 32'(we_k), 32'd3);
        check("dep_wr_data", wd, 32'd24);
        check("dep_r3", regs[3], 32'd12);
        check("dep_r6", regs[6], 32'd24);

        // illegal opcodes: pulse once, no write, registers untouched
        for (int op = 6; op <= 7; op++) begin
            for (int i = 0; i < 8; i++) snap[i] = regs[i];
            run_op(3'(op), 3'd5, 3'd1, 3'd2, wc, we_k, wa, wd, ic, ie, re);
            $display("illegal op=%0d ill_count=%0d ill_edge=%0d wr_count=%0d ready_edge=%0d",
                     op, ic, ie, wc, re);
            check("ill_count", 32'(ic), 32'd1);
            check("ill_edge", 32'(ie), 32'd2);
            check("ill_wr_count", 32'(wc), 32'd0);
            check("ill_ready_edge", 32'(re), 32'd3);
            for (int i = 0; i < 8; i++) check($sformatf("ill_r%0d", i), regs[i], snap[i]);
        end

        // reset during MUL at E10
        for (int i = 0; i < 8; i++) snap[i] = regs[i];
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_op = 3'd5; bus.i_rd = 3'd4; bus.i_rs1 = 3'd1; bus.i_rs2 = 3'd2;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        late_wr = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bus.o_write_en) late_wr++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mulrst_ready", 32'(bus.o_ready), 32'd1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.o_write_en) late_wr++;
        end
        $display("mul reset at E10 writes_seen=%0d", late_wr);
        check("mulrst_no_write", 32'(late_wr), 32'd0);
        check("mulrst_r4", regs[4], snap[4]);

        run_op(3'd0, 3'd4, 3'd1, 3'd2, wc, we_k, wa, wd, ic, ie, re);
        $display("post-reset add wr_edge=%0d data=%h", we_k, wd);
        check("postrst_wr_count", 32'(wc), 32'd1);
        check("postrst_wr_edge", 32'(we_k), 32'd3);
        check("postrst_r4", regs[4], 32'd12);

        // reset coinciding with WB suppresses the write
        seed_reg(3'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_op = 3'd0; bus.i_rd = 3'd7; bus.i_rs1 = 3'd1; bus.i_rs2 = 3'd2;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("wbrst_write_en", 32'(bus.o_write_en), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("reset in WB r7=%h ready=%0d", regs[7], bus.o_ready);
        check("wbrst_r7", regs[7], 32'hDEAD_BEEF);
        check("wbrst_ready", 32'(bus.o_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
